// File: rtl/verilab_i2c_master_ctrl.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, STOP, one-cycle response.
// Define VERILAB_I2C_CLK_STRETCH_EN to let a target stretch SCL during the high quarters.
module verilab_i2c_master_ctrl #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_AACK  = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_DACK  = 3'd5;
    localparam logic [2:0] S_STOP  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [9:0] DIV_LAST = 10'(DIV - 1);

    logic [2:0] state;
    logic [9:0] div_cnt;
    logic [1:0] qtr;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] wdata_q;
    logic       rd_q;
    logic       hold;
    logic       running;
    logic       accept;
    logic       tick;
    logic       sample;
    logic       bit_end;

`ifdef VERILAB_I2C_CLK_STRETCH_EN
    // Q2/Q3 are the SCL-released quarters; a low scl_in there means the target is stretching.
    assign hold = qtr[1] && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold          = 1'b0;
`endif

    assign running = (state != S_IDLE) && (state != S_DONE);
    assign accept  = cmd_valid && cmd_ready;
    assign tick    = running && !hold && (div_cnt == DIV_LAST);
    assign sample  = tick && (qtr == 2'd2);
    assign bit_end = tick && (qtr == 2'd3);

    assign cmd_ready = (state == S_IDLE) && !reset;
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            qtr       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            rsp_rdata <= '0;
            rsp_nack  <= 1'b0;
        end else begin
            if (!running || tick) begin
                div_cnt <= '0;
            end else if (!hold) begin
                div_cnt <= div_cnt + 10'd1;
            end
            if (tick) begin
                qtr <= qtr + 2'd1;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state     <= S_START;
                        qtr       <= '0;
                        bit_cnt   <= '0;
                        shift     <= {cmd_addr, cmd_rd};
                        wdata_q   <= cmd_wdata;
                        rd_q      <= cmd_rd;
                        rsp_rdata <= '0;
                        rsp_nack  <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) state <= S_ADDR;
                end
                S_ADDR: begin
                    if (bit_end) begin
                        shift   <= {shift[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_AACK;
                    end
                end
                S_AACK: begin
                    if (sample) rsp_nack <= sda_in;
                    if (bit_end) begin
                        shift <= rd_q ? 8'h00 : wdata_q;
                        state <= rsp_nack ? S_STOP : S_DATA;
                    end
                end
                S_DATA: begin
                    if (sample && rd_q) shift <= {shift[6:0], sda_in};
                    if (bit_end) begin
                        if (!rd_q) shift <= {shift[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_DACK;
                    end
                end
                S_DACK: begin
                    // On reads the master leaves SDA released here, signalling NACK to end the read.
                    if (sample && !rd_q) rsp_nack <= sda_in;
                    if (bit_end) state <= S_STOP;
                end
                S_STOP: begin
                    if (bit_end) begin
                        state <= S_DONE;
                        if (rd_q && !rsp_nack) rsp_rdata <= shift;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: both outputs get a default first so no path through the case can infer a latch.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state)
            S_START: sda_oe = qtr[1];
            S_ADDR: begin
                scl_oe = !qtr[1];
                sda_oe = !shift[7];
            end
            S_AACK, S_DACK: scl_oe = !qtr[1];
            S_DATA: begin
                scl_oe = !qtr[1];
                sda_oe = !rd_q && !shift[7];
            end
            S_STOP: begin
                scl_oe = !qtr[1];
                sda_oe = (qtr != 2'd3);
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_verilab_i2c_master_ctrl.sv
// Bench for verilab_i2c_master_ctrl: behavioural I2C target on the bus, latency/response model,
// directed corner cases plus randomized transfers.
module tb_verilab_i2c_master_ctrl;
    localparam int DIV_A = 4;
    localparam int DIV_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       cmd_valid, cmd_rd;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       cmd_ready, rsp_valid, rsp_nack, scl_oe, sda_oe, busy;
    logic [7:0] rsp_rdata;
    logic       scl_in, sda_in;
    logic       stretch = 1'b0;
    logic       s_low = 1'b0;

    assign scl_in = !scl_oe && !stretch;
    assign sda_in = !sda_oe && !s_low;

    verilab_i2c_master_ctrl #(.DIV(DIV_A)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe), .busy(busy)
    );

    // Second instance with no target on its bus: every address is NACKed.
    logic       c2_valid, c2_ready, c2_rsp_valid, c2_rsp_nack, c2_scl_oe, c2_sda_oe, c2_busy;
    logic [7:0] c2_rsp_rdata;
    logic       c2_scl_in, c2_sda_in;
    assign c2_scl_in = !c2_scl_oe;
    assign c2_sda_in = !c2_sda_oe;

    verilab_i2c_master_ctrl #(.DIV(DIV_B)) dut2 (
        .clk(clk), .reset(reset),
        .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_rd(1'b0),
        .cmd_addr(7'h11), .cmd_wdata(8'h6B),
        .rsp_valid(c2_rsp_valid), .rsp_rdata(c2_rsp_rdata), .rsp_nack(c2_rsp_nack),
        .scl_in(c2_scl_in), .sda_in(c2_sda_in), .scl_oe(c2_scl_oe), .sda_oe(c2_sda_oe), .busy(c2_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural target: watches bus levels, counts SCL clocks per byte, ACKs and serves reads.
    logic       s_ack_addr = 1'b0;
    logic       s_ack_data = 1'b0;
    logic [7:0] s_rbyte = 8'h00;
    logic [7:0] mon_byte0 = 8'h00;
    logic [7:0] mon_byte1 = 8'h00;
    logic       mon_dack_oe = 1'b0;
    logic       mon_dack_seen = 1'b0;
    logic       scl_q = 1'b1, sda_q = 1'b1;
    logic       sel = 1'b0, rd_x = 1'b0;
    logic [7:0] sh = 8'h00;
    int         rises = 0, byte_n = 0;

    always @(negedge clk) begin
        logic scl_l, sda_l;
        scl_l = !scl_oe;
        sda_l = sda_in;
        if (reset) begin
            s_low = 1'b0; rises = 0; byte_n = 0; sel = 1'b0; rd_x = 1'b0;
            scl_l = 1'b1; sda_l = 1'b1;
        end else if (scl_q && scl_l && sda_q && !sda_l) begin
            rises = 0; byte_n = 0; sel = 1'b0; rd_x = 1'b0; s_low = 1'b0;
            sh = 8'h00; mon_dack_seen = 1'b0;
        end else if (scl_q && scl_l && !sda_q && sda_l) begin
            s_low = 1'b0; byte_n = 2;
        end else if (!scl_q && scl_l) begin
            rises++;
            if (rises <= 8) sh = {sh[6:0], sda_l};
            if (rises == 9 && byte_n == 1) begin
                mon_dack_oe   = sda_oe;
                mon_dack_seen = 1'b1;
            end
        end else if (scl_q && !scl_l) begin
            if (rises == 8) begin
                if (byte_n == 0) begin
                    mon_byte0 = sh; rd_x = sh[0]; sel = s_ack_addr; s_low = s_ack_addr;
                end else if (byte_n == 1) begin
                    mon_byte1 = sh; s_low = sel && !rd_x && s_ack_data;
                end
            end else if (rises == 9) begin
                rises = 0;
                byte_n++;
                s_low = (byte_n == 1 && sel && rd_x) ? !s_rbyte[7] : 1'b0;
            end else if (byte_n == 1 && sel && rd_x && rises >= 1 && rises <= 7) begin
                s_low = !s_rbyte[7 - rises];
            end
        end
        scl_q = scl_l;
        sda_q = sda_l;
    end

    // One transfer on the DIV_A instance; expectations come from the protocol rules only.
    task automatic run_xfer(input logic rd, input logic [6:0] addr, input logic [7:0] wdata,
                            input logic ack_a, input logic ack_d, input logic [7:0] rbyte,
                            input int stretch_len, input logic hold_busy, input int reset_at);
        int         n;
        int         exp_lat;
        logic       exp_nack;
        logic [7:0] exp_rdata;
        logic       ready_in_busy;
        logic       late_rsp;
        exp_nack  = !ack_a || (!rd && !ack_d);
        exp_rdata = (rd && ack_a) ? rbyte : 8'h00;
        exp_lat   = (ack_a ? 80 : 44) * DIV_A + 1;
`ifdef VERILAB_I2C_CLK_STRETCH_EN
        exp_lat   = exp_lat + stretch_len;
`endif
        s_ack_addr = ack_a;
        s_ack_data = ack_d;
        s_rbyte    = rbyte;

        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        check("busy_after_accept", busy, 1);
        if (hold_busy) begin
            cmd_addr  = ~addr;
            cmd_wdata = ~wdata;
        end else begin
            cmd_valid = 1'b0;
        end

        ready_in_busy = 1'b0;
        while (!rsp_valid && n < 2000) begin
            if (cmd_ready) ready_in_busy = 1'b1;
            if (stretch_len > 0 && n == 74) stretch = 1'b1;
            if (stretch_len > 0 && n == 74 + stretch_len) stretch = 1'b0;
            if (reset_at > 0 && n == reset_at) break;
            @(posedge clk);
            n++;
            @(negedge clk);
        end

        if (reset_at > 0) begin
            check("busy_before_reset", busy, 1);
            check("scl_low_before_reset", scl_oe, 1);
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("rst_scl_oe", scl_oe, 0);
            check("rst_sda_oe", sda_oe, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_cmd_ready", cmd_ready, 0);
            check("rst_busy", busy, 0);
            reset = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("ready_after_reset", cmd_ready, 1);
            late_rsp = 1'b0;
            repeat (400) begin
                @(negedge clk);
                if (rsp_valid) late_rsp = 1'b1;
            end
            check("no_rsp_after_reset", late_rsp, 0);
            return;
        end

        check("latency", n, exp_lat);
        check("rsp_valid", rsp_valid, 1);
        check("busy_at_done", busy, 1);
        check("rsp_nack", rsp_nack, exp_nack);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("ready_in_busy", ready_in_busy, 0);
        check("addr_byte_on_bus", mon_byte0, {addr, rd});
        if (ack_a && !rd) check("wdata_byte_on_bus", mon_byte1, wdata);
        if (ack_a && rd)  check("dack_sda_released", {mon_dack_seen, mon_dack_oe}, 2'b10);
        if (!hold_busy) begin
            @(negedge clk);
            check("rsp_one_cycle", rsp_valid, 0);
            check("busy_cleared", busy, 0);
            check("rdata_hold", rsp_rdata, exp_rdata);
            check("nack_hold", rsp_nack, exp_nack);
        end
    endtask

    int n2;

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_rd    = 1'b0;
        cmd_addr  = 7'h00;
        cmd_wdata = 8'h00;
        c2_valid  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 0);
        check("reset_scl_oe", scl_oe, 0);
        check("reset_sda_oe", sda_oe, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_rsp_nack", rsp_nack, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;

        // Write 0x50 / 0xA5 with ACKs, then read 0x50 returning 0x3C.
        run_xfer(1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 0, 1'b0, 0);
        run_xfer(1'b1, 7'h50, 8'h00, 1'b1, 1'b1, 8'h3C, 0, 1'b0, 0);

        // Write data NACK and read with address NACK.
        run_xfer(1'b0, 7'h22, 8'h81, 1'b1, 1'b0, 8'h00, 0, 1'b0, 0);
        run_xfer(1'b1, 7'h7F, 8'h00, 1'b0, 1'b1, 8'hFF, 0, 1'b0, 0);

        // DIV=2 write with nobody answering: STOP right after AACK.
        @(negedge clk);
        check("u2_ready", c2_ready, 1);
        c2_valid = 1'b1;
        @(posedge clk);
        n2 = 1;
        @(negedge clk);
        c2_valid = 1'b0;
        while (!c2_rsp_valid && n2 < 1000) begin
            @(posedge clk);
            n2++;
            @(negedge clk);
        end
        check("u2_latency", n2, 44 * DIV_B + 1);
        check("u2_rsp_nack", c2_rsp_nack, 1);
        check("u2_rsp_rdata", c2_rsp_rdata, 0);

        // Reset in the middle of a write, then a normal transfer.
        run_xfer(1'b0, 7'h2A, 8'h5A, 1'b1, 1'b1, 8'h00, 0, 1'b0, 100);
        run_xfer(1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 0, 1'b0, 0);

        // Command held valid with a different address while busy, then accepted back to back.
        run_xfer(1'b0, 7'h33, 8'h12, 1'b1, 1'b1, 8'h00, 0, 1'b1, 0);
        run_xfer(1'b0, 7'h4C, 8'hED, 1'b1, 1'b1, 8'h00, 0, 1'b0, 0);

        // Target holds SCL low for 50 cycles during an address bit.
        run_xfer(1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 50, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            run_xfer(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     8'($urandom), 0, 1'b0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/verilab_i2c_master_ctrl.md
VERILAB_I2C_MASTER_CTRL -- requirements
Module: verilab_i2c_master_ctrl

Interface
REQ-001 Parameter DIV, default 4: clk cycles per quarter SCL period; legal range 1..1023.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_rd  input  1  1 = single-byte read, 0 = single-byte write.
REQ-007 cmd_addr  input  7  7-bit target address.
REQ-008 cmd_wdata  input  8  write byte.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_rdata  output  8  read byte; 0 for writes and NACKed transfers.
REQ-011 rsp_nack  output  1  target NACKed address or write data; valid with rsp_valid.
REQ-012 scl_in / sda_in  input  1 each  sampled bus levels.
REQ-013 scl_oe / sda_oe  output  1 each  1 = pull line low; 0 = release (open drain).
REQ-014 busy  output  1  high from command acceptance until the rsp_valid cycle inclusive.

Function
REQ-015 The block SHALL run FSM states IDLE, START, ADDR, AACK, DATA, DACK, STOP, DONE.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is latched on the accept cycle and cmd_* inputs are ignored afterwards.
REQ-017 A quarter tick SHALL fire every DIV clk cycles while not in IDLE/DONE; the divider SHALL restart at 0 on acceptance.
REQ-018 Each bit SHALL span 4 quarters: Q0-Q1 SCL low (SDA changes at Q0 start), Q2-Q3 SCL released; sda_in is sampled at Q3 start.
REQ-019 START SHALL span 4 quarters: SDA released then pulled low at Q2 while SCL released; SCL pulled low at Q3 end.
REQ-020 ADDR SHALL shift out {cmd_addr, cmd_rd} MSB first (8 bits); AACK SHALL release SDA and sample ACK (0 = ACK).
REQ-021 Address NACK SHALL skip DATA/DACK, go to STOP, and set rsp_nack=1.
REQ-022 Write DATA SHALL shift out cmd_wdata MSB first; DACK SHALL sample ACK, and a NACK SHALL set rsp_nack=1.
REQ-023 Read DATA SHALL release SDA and shift sda_in into rsp_rdata MSB first; DACK SHALL release SDA (master NACK); rsp_nack=0.
REQ-024 STOP SHALL span 4 quarters: SDA pulled low at Q0, SCL released at Q2, SDA released at Q3; then DONE.
REQ-025 DONE SHALL last 1 cycle with rsp_valid=1, then IDLE; rsp_rdata/rsp_nack SHALL hold until the next acceptance.
REQ-026 Acceptance to rsp_valid SHALL take 80*DIV+1 cycles for ACKed transfers and 44*DIV+1 for address NACK.
REQ-027 cmd_valid while busy SHALL have no effect; back-to-back commands SHALL be accepted in the cycle after DONE.

Reset
REQ-028 While reset=1: state IDLE, scl_oe=0, sda_oe=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_nack=0, busy=0, divider=0.
REQ-029 Reset mid-transaction SHALL release both lines on the next clk edge with no rsp_valid; cmd_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-030 With VERILAB_I2C_CLK_STRETCH_EN defined, the quarter counter SHALL freeze in Q2/Q3 while scl_in=0 (target stretching), resuming when scl_in=1; REQ-026 latency extends by the stretched cycles.
REQ-031 Without VERILAB_I2C_CLK_STRETCH_EN, scl_in SHALL be ignored and timing SHALL be exactly REQ-026.

Verification
REQ-032 DIV=4, write addr 0x50 data 0xA5, target ACKs -> SDA bits 0xA0 then 0xA5, rsp_valid at cycle 321, rsp_nack=0, rsp_rdata=0.
REQ-033 DIV=4, read addr 0x50, target drives 0x3C -> rsp_rdata=0x3C, rsp_nack=0, SDA released in DACK, rsp_valid at cycle 321.
REQ-034 DIV=2, write addr 0x11, no ACK -> STOP follows AACK, rsp_nack=1, rsp_valid at cycle 89.
REQ-035 reset pulsed at cycle 100 of a DIV=4 write -> scl_oe=sda_oe=0 next cycle, no rsp_valid, next command completes normally.
REQ-036 cmd_valid held during busy with different addr -> ignored; second command accepted the cycle after rsp_valid.
REQ-037 VERILAB_I2C_CLK_STRETCH_EN defined, DIV=4, scl_in held 0 for 50 cycles in bit 3 of ADDR -> rsp_valid at cycle 371; undefined -> cycle 321.
